l2_banked_sram_model: RTL and testbench

L2_BANKED_SRAM_MODEL -- requirements
Module: l2_banked_sram_model

---
 rtl/l2_banked_sram_model.sv | 182 ++++++++++++++++++
 tb/tb_l2_banked_sram_model.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_banked_sram_model.sv
// l2_banked_sram_model
// Banked L2 SRAM behavioural model: NB_BANKS cuts selected by the top
// address bits, byte-masked writes, one-cycle read latency.
// Optional per-cut idle sleep / wake power management is compiled in when
// the macro L2_BANK_SLEEP_EN is defined; otherwise every cut is always
// active and BANK_SLEEP is tied low.

module l2_banked_sram_model #(
  parameter int NB_BANKS    = 8,
  parameter int BANK_ADDR_W = 12,
  parameter int DATA_W      = 32,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   scan_en_in,
  input  logic                                   CEN,
  input  logic                                   WEN,
  input  logic [DATA_W/8-1:0]                    BEN,
  input  logic [BANK_ADDR_W+$clog2(NB_BANKS)-1:0] A,
  input  logic [DATA_W-1:0]                      D,
  output logic                                   GNT,
  output logic [DATA_W-1:0]                      Q,
  output logic                                   RVALID,
  output logic [NB_BANKS-1:0]                    BANK_SLEEP
);

  localparam int SEL_W    = $clog2(NB_BANKS);
  localparam int NB_BYTES = DATA_W / 8;
  localparam int DEPTH    = 1 << BANK_ADDR_W;

  logic [SEL_W-1:0]       cut_s;
  logic [BANK_ADDR_W-1:0] word_s;
  logic [NB_BANKS-1:0]    cut_active_s;
  logic [NB_BANKS-1:0]    acc_cut_s;
  logic                   gnt_s;
  logic [DATA_W-1:0]      bank_rd_s [NB_BANKS];

  logic [SEL_W-1:0]       sel_r;
  logic                   rvalid_r;
  logic [DATA_W-1:0]      q_hold_r;

  assign cut_s  = A[BANK_ADDR_W +: SEL_W];
  assign word_s = A[BANK_ADDR_W-1:0];

  // Grant decode: a request is accepted only when its target cut is active
  always_comb begin
    gnt_s     = 1'b0;
    acc_cut_s = {NB_BANKS{1'b0}};
    if (!RST && !scan_en_in && !CEN && cut_active_s[cut_s]) begin
      gnt_s            = 1'b1;
      acc_cut_s[cut_s] = 1'b1;
    end else begin
      gnt_s     = 1'b0;
      acc_cut_s = {NB_BANKS{1'b0}};
    end
  end

  for (genvar g = 0; g < NB_BANKS; g++) begin : g_cut
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_r;

    // Cut storage: byte-masked write or read capture; contents survive reset
    always_ff @(posedge CLK) begin
      if (acc_cut_s[g]) begin
        if (!WEN) begin
          for (int b = 0; b < NB_BYTES; b++) begin
            if (!BEN[b]) begin
              mem_r[word_s][b*8 +: 8] <= D[b*8 +: 8];
            end
          end
        end else begin
          rd_r <= mem_r[word_s];
        end
      end
    end

    assign bank_rd_s[g] = rd_r;
  end

`ifdef L2_BANK_SLEEP_EN
  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_SLEEP  = 2'd1,
    ST_WAKE   = 2'd2
  } cut_state_t;

  localparam int CNT_MAX = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam bit               SLEEP_ON  = (IDLE_CYCLES > 0);

  for (genvar g = 0; g < NB_BANKS; g++) begin : g_pm
    cut_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sleep_r;

    // Per-cut power FSM; the request cycle that hits a sleeping cut counts
    // as the first wake cycle, so GNT stays low for WAKE_CYCLES cycles
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        state_r <= ST_ACTIVE;
        cnt_r   <= {CNT_W{1'b0}};
        sleep_r <= 1'b0;
      end else if (scan_en_in) begin
        state_r <= state_r;
        cnt_r   <= cnt_r;
        sleep_r <= sleep_r;
      end else begin
        case (state_r)
          ST_ACTIVE: begin
            if (acc_cut_s[g]) begin
              cnt_r <= {CNT_W{1'b0}};
            end else if (SLEEP_ON && (cnt_r == IDLE_LAST)) begin
              state_r <= ST_SLEEP;
              cnt_r   <= {CNT_W{1'b0}};
              sleep_r <= 1'b1;
            end else if (SLEEP_ON) begin
              cnt_r <= cnt_r + CNT_W'(1);
            end else begin
              cnt_r <= {CNT_W{1'b0}};
            end
          end
          ST_SLEEP: begin
            if (!CEN && (cut_s == SEL_W'(g))) begin
              state_r <= ST_WAKE;
              cnt_r   <= CNT_W'(1);
            end else begin
              state_r <= ST_SLEEP;
            end
          end
          ST_WAKE: begin
            if (cnt_r >= WAKE_LAST) begin
              state_r <= ST_ACTIVE;
              cnt_r   <= {CNT_W{1'b0}};
              sleep_r <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          default: begin
            state_r <= ST_ACTIVE;
            cnt_r   <= {CNT_W{1'b0}};
            sleep_r <= 1'b0;
          end
        endcase
      end
    end

    assign cut_active_s[g] = (state_r == ST_ACTIVE);
    assign BANK_SLEEP[g]   = sleep_r;
  end
`else
  assign cut_active_s = {NB_BANKS{1'b1}};
  assign BANK_SLEEP   = {NB_BANKS{1'b0}};
`endif

  // Read return: track the cut of each accepted access and hold the last
  // returned word while no new read data is valid
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sel_r    <= {SEL_W{1'b0}};
      rvalid_r <= 1'b0;
      q_hold_r <= {DATA_W{1'b0}};
    end else begin
      if (gnt_s) begin
        sel_r <= cut_s;
      end
      rvalid_r <= gnt_s & WEN;
      if (rvalid_r) begin
        q_hold_r <= bank_rd_s[sel_r];
      end
    end
  end

  assign GNT    = gnt_s;
  assign RVALID = rvalid_r;
  assign Q      = rvalid_r ? bank_rd_s[sel_r] : q_hold_r;

endmodule

// File: tb/tb_l2_banked_sram_model.sv
// Self-checking bench for l2_banked_sram_model (default parameters).
// Expectations track L2_BANK_SLEEP_EN so the same bench covers both builds.

module tb_l2_banked_sram_model;

  localparam int NB   = 8;
  localparam int IDLE = 16;
  localparam int WAKE = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        scan_en_in;
  logic        CEN;
  logic        WEN;
  logic [3:0]  BEN;
  logic [14:0] A;
  logic [31:0] D;
  logic        GNT;
  logic [31:0] Q;
  logic        RVALID;
  logic [7:0]  BANK_SLEEP;

  int total = 0;
  int bad   = 0;

  // reference model: word store, per-cut refusal state, read return
  logic [31:0] mem_m [int];
  int          off_m  [NB];   // 0 = usable, -1 = asleep, k>0 = k more refused cycles
  int          idle_m [NB];   // consecutive usable cycles without an accepted access
  logic [31:0] q_m;
  logic        rvalid_m;

  always #5 CLK = ~CLK;

  l2_banked_sram_model #(
    .NB_BANKS(NB), .BANK_ADDR_W(12), .DATA_W(32),
    .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)
  ) dut (
    .CLK(CLK), .RST(RST), .scan_en_in(scan_en_in), .CEN(CEN), .WEN(WEN),
    .BEN(BEN), .A(A), .D(D), .GNT(GNT), .Q(Q), .RVALID(RVALID),
    .BANK_SLEEP(BANK_SLEEP)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sleep_exp();
    logic [7:0] r;
    for (int k = 0; k < NB; k++) r[k] = (off_m[k] != 0);
    return r;
  endfunction

  task automatic model_reset();
    q_m      = 32'h0;
    rvalid_m = 1'b0;
    for (int k = 0; k < NB; k++) begin
      off_m[k]  = 0;
      idle_m[k] = 0;
    end
  endtask

  // one clock cycle: check GNT mid-cycle, advance the model, check outputs after the edge
  task automatic tick(output bit granted);
    int          c;
    bit          g;
    logic [31:0] w;
    c = int'(A[14:12]);
    g = !RST && !scan_en_in && !CEN && (off_m[c] == 0);
    @(negedge CLK);
    chk("gnt", GNT, g);
    granted  = GNT;
    rvalid_m = 1'b0;
    if (RST) begin
      model_reset();
    end else begin
      if (g && !WEN) begin
        w = mem_m.exists(int'(A)) ? mem_m[int'(A)] : 32'h0;
        for (int b = 0; b < 4; b++) if (!BEN[b]) w[b*8 +: 8] = D[b*8 +: 8];
        mem_m[int'(A)] = w;
      end else if (g) begin
        rvalid_m = 1'b1;
        q_m      = mem_m[int'(A)];
      end
`ifdef L2_BANK_SLEEP_EN
      if (!scan_en_in) begin
        for (int k = 0; k < NB; k++) begin
          if (off_m[k] == 0) begin
            if (g && c == k) idle_m[k] = 0;
            else begin
              idle_m[k]++;
              if (idle_m[k] == IDLE) begin
                off_m[k]  = -1;
                idle_m[k] = 0;
              end
            end
          end else if (off_m[k] < 0) begin
            if (!CEN && c == k) off_m[k] = WAKE - 1;
          end else begin
            off_m[k]--;
          end
        end
      end
`endif
    end
    @(posedge CLK);
    #1;
    chk("rvalid", RVALID, rvalid_m);
    chk("q", Q, q_m);
    chk("bank_sleep", BANK_SLEEP, sleep_exp());
  endtask

  task automatic access(bit wr, logic [14:0] a, logic [31:0] d, logic [3:0] ben,
                        int max_wait, output int waited);
    bit got;
    CEN = 1'b0; WEN = !wr; A = a; D = d; BEN = ben;
    waited = 0;
    got    = 1'b0;
    for (int i = 0; i <= max_wait; i++) begin
      tick(got);
      if (got) break;
      waited++;
    end
    chk("granted_in_bound", got, 1'b1);
    CEN = 1'b1;
    WEN = 1'b1;
  endtask

  task automatic idle(int n);
    bit g;
    CEN = 1'b1;
    repeat (n) tick(g);
  endtask

  initial begin
    int          w;
    bit          g;
    logic [14:0] a;
    logic [31:0] d, d3, d5;

    RST = 1'b1; scan_en_in = 1'b0; CEN = 1'b1; WEN = 1'b1;
    BEN = 4'hF; A = 15'h0; D = 32'h0;
    model_reset();
    @(posedge CLK);
    #1;
    chk("rst_q", Q, 32'h0);
    chk("rst_rvalid", RVALID, 1'b0);
    chk("rst_sleep", BANK_SLEEP, 8'h00);
    tick(g);
    tick(g);
    RST = 1'b0;

    // full write then read back
    access(1'b1, 15'h0000, 32'hDEADBEEF, 4'b0000, 4, w);
    access(1'b0, 15'h0000, 32'h0, 4'hF, 4, w);
    chk("deadbeef_rvalid", RVALID, 1'b1);
    chk("deadbeef_q", Q, 32'hDEADBEEF);
    tick(g);
    chk("rvalid_one_cycle", RVALID, 1'b0);
    chk("q_holds", Q, 32'hDEADBEEF);

    // partial write merges into earlier full write
    access(1'b1, 15'h0004, 32'hAABBCCDD, 4'b0000, 4, w);
    access(1'b1, 15'h0004, 32'h11223344, 4'b1100, 4, w);
    access(1'b0, 15'h0004, 32'h0, 4'hF, 4, w);
    chk("merge_q", Q, 32'hAABB3344);

    // random traffic over all cuts
    for (int i = 0; i < 24; i++) begin
      a = {3'($urandom_range(0, 7)), 12'($urandom_range(0, 3))};
      d = $urandom;
      if (!mem_m.exists(int'(a))) access(1'b1, a, d, 4'b0000, 4, w);
      else if ($urandom_range(0, 1) == 1) access(1'b1, a, d, 4'($urandom_range(0, 15)), 4, w);
      else access(1'b0, a, 32'h0, 4'hF, 4, w);
    end

    // cut 3 idles into sleep, then wakes on a read
    d3 = $urandom | 32'h1;
    access(1'b1, 15'h3010, d3, 4'b0000, 4, w);
    idle(IDLE - 1);
    chk("cut3_awake_at_15", BANK_SLEEP[3], 1'b0);
    idle(1);
`ifdef L2_BANK_SLEEP_EN
    chk("cut3_asleep_at_16", BANK_SLEEP[3], 1'b1);
`else
    chk("cut3_asleep_at_16", BANK_SLEEP[3], 1'b0);
`endif
    access(1'b0, 15'h3010, 32'h0, 4'hF, 6, w);
`ifdef L2_BANK_SLEEP_EN
    chk("cut3_wake_wait", w, WAKE);
`else
    chk("cut3_wake_wait", w, 0);
`endif
    chk("cut3_retained", Q, d3);

    // access on the cycle the idle count expires keeps cut 0 awake
    d = $urandom | 32'h1;
    access(1'b1, 15'h0008, d, 4'b0000, 6, w);
    idle(IDLE - 1);
    access(1'b0, 15'h0008, 32'h0, 4'hF, 4, w);
    chk("cut0_expiry_wait", w, 0);
    chk("cut0_expiry_q", Q, d);
    chk("cut0_stays_awake", BANK_SLEEP[0], 1'b0);
    idle(1);
    chk("cut0_still_awake", BANK_SLEEP[0], 1'b0);

    // reset in the middle of waking cut 5
    d5 = $urandom | 32'h1;
    access(1'b1, 15'h5123, d5, 4'b0000, 6, w);
    idle(IDLE);
    CEN = 1'b0; WEN = 1'b1; A = 15'h5123;
    tick(g);
    RST = 1'b1;
    model_reset();
    #1;
    chk("midwake_rst_sleep", BANK_SLEEP, 8'h00);
    chk("midwake_rst_rvalid", RVALID, 1'b0);
    chk("midwake_rst_q", Q, 32'h0);
    tick(g);
    RST = 1'b0;
    CEN = 1'b1;
    access(1'b0, 15'h5123, 32'h0, 4'hF, 4, w);
    chk("cut5_post_rst_wait", w, 0);
    chk("cut5_retained", Q, d5);

    // scan mode blocks access and freezes power state
    scan_en_in = 1'b1;
    CEN = 1'b0; WEN = 1'b0; A = 15'h1001; D = $urandom; BEN = 4'b0000;
    repeat (5) tick(g);
    scan_en_in = 1'b0;
    d = $urandom;
    access(1'b1, 15'h1001, d, 4'b0000, 6, w);
    access(1'b0, 15'h1001, 32'h0, 4'hF, 4, w);
    chk("scan_then_q", Q, d);

    // long idle stretch
    idle(100);
`ifdef L2_BANK_SLEEP_EN
    chk("long_idle_sleep", BANK_SLEEP, 8'hFF);
`else
    chk("long_idle_sleep", BANK_SLEEP, 8'h00);
`endif
    access(1'b0, 15'h0008, 32'h0, 4'hF, 6, w);
`ifdef L2_BANK_SLEEP_EN
    chk("long_idle_wait", w, WAKE);
`else
    chk("long_idle_wait", w, 0);
`endif
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
